// File: rtl/ddr5_bank_responder.sv
// rtl/ddr5_bank_responder.sv - DDR5 bank-set device model: row/timing tracking, read/write bursts, violation flags
// Optional macro DDR5_RESP_VIOL_COUNT_EN adds a saturating viol_count output.
module ddr5_bank_responder #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = $clog2(NUM_BANKS),
  parameter int ROW_W     = 16,
  parameter int COL_W     = 10,
  parameter int DATA_W    = 32,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TRAS      = 8,
  parameter int TCL       = 5,
  parameter int TCWD      = 3,
  parameter int TBURST    = 4,
  parameter int TRFC      = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_op,
  input  logic [BANK_W-1:0]    cmd_bank,
  input  logic [ROW_W-1:0]     cmd_row,
  input  logic [COL_W-1:0]     cmd_col,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 wr_ready,
  input  logic                 wr_valid,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_done,
  output logic [DATA_W-1:0]    wr_checksum,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 viol_valid,
  output logic [2:0]           viol_code
`ifdef DDR5_RESP_VIOL_COUNT_EN
  ,output logic [15:0]         viol_count
`endif
);
  localparam logic [2:0] OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3, OP_PRE = 3'd4, OP_REF = 3'd5;

  typedef enum logic [2:0] {B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING, B_REFRESHING} bank_st_t;
  typedef enum logic [2:0] {E_IDLE, E_RD_WAIT, E_RD_BURST, E_WR_WAIT, E_WR_BURST} eng_st_t;

  bank_st_t         bank_st [NUM_BANKS];
  bank_st_t         bank_st_n [NUM_BANKS];
  logic [ROW_W-1:0] open_row [NUM_BANKS];
  logic [ROW_W-1:0] open_row_n [NUM_BANKS];
  logic [7:0]       phase [NUM_BANKS];
  logic [7:0]       phase_n [NUM_BANKS];
  logic [7:0]       ras [NUM_BANKS];
  logic [7:0]       ras_n [NUM_BANKS];

  eng_st_t           eng_st, eng_st_n;
  logic [7:0]        cnt, cnt_n, beat, beat_n;
  logic [ROW_W-1:0]  lat_row;
  logic [COL_W-1:0]  lat_col;
  logic [BANK_W-1:0] lat_bank;
  logic [DATA_W-1:0] acc, acc_n, checksum_n, beat_data;
  logic [2:0]        code_q, viol_cmd;
  logic              act_ok, rd_ok, wr_ok, pre_ok, ref_ok, ref_clear, viol_dp;
  bank_st_t          sel_st;
  logic [7:0]        sel_ras;

  assign sel_st  = bank_st[cmd_bank];
  assign sel_ras = ras[cmd_bank];

  // Commands are judged against registered state only, so same-cycle expiries are not yet visible.
  always_comb begin
    ref_clear = (eng_st == E_IDLE);
    for (int i = 0; i < NUM_BANKS; i++)
      if (bank_st[i] != B_IDLE) ref_clear = 1'b0;
    viol_cmd = 3'd0;
    act_ok = 1'b0; rd_ok = 1'b0; wr_ok = 1'b0; pre_ok = 1'b0; ref_ok = 1'b0;
    if (cmd_valid) begin
      case (cmd_op)
        OP_ACT: if (sel_st == B_IDLE) act_ok = 1'b1; else viol_cmd = 3'd1;
        OP_RD, OP_WR: begin
          if (sel_st != B_ACTIVE) viol_cmd = 3'd2;
          else if (eng_st != E_IDLE) viol_cmd = 3'd5;
          else begin
            rd_ok = (cmd_op == OP_RD);
            wr_ok = (cmd_op == OP_WR);
          end
        end
        OP_PRE: begin
          if (sel_st == B_ACTIVE && sel_ras == 8'd0) pre_ok = 1'b1;
          else if (sel_st != B_IDLE) viol_cmd = 3'd3;
        end
        OP_REF: if (ref_clear) ref_ok = 1'b1; else viol_cmd = 3'd4;
        3'd6, 3'd7: viol_cmd = 3'd7;
        default: ;
      endcase
    end
  end

  // A bank leaves a timed state in the same update that its phase reaches 0.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_st_n[i]  = bank_st[i];
      open_row_n[i] = open_row[i];
      phase_n[i]    = (phase[i] != 8'd0) ? phase[i] - 8'd1 : 8'd0;
      ras_n[i]      = (ras[i] != 8'd0) ? ras[i] - 8'd1 : 8'd0;
      case (bank_st[i])
        B_ACTIVATING:               if (phase[i] <= 8'd1) bank_st_n[i] = B_ACTIVE;
        B_PRECHARGING, B_REFRESHING: if (phase[i] <= 8'd1) bank_st_n[i] = B_IDLE;
        default: ;
      endcase
      if (act_ok && cmd_bank == BANK_W'(i)) begin
        open_row_n[i] = cmd_row;
        phase_n[i]    = 8'(TRCD - 1);
        ras_n[i]      = 8'(TRAS - 1);
        bank_st_n[i]  = (TRCD == 1) ? B_ACTIVE : B_ACTIVATING;
      end
      if (pre_ok && cmd_bank == BANK_W'(i)) begin
        phase_n[i]   = 8'(TRP - 1);
        bank_st_n[i] = (TRP == 1) ? B_IDLE : B_PRECHARGING;
      end
      if (ref_ok) begin
        phase_n[i]   = 8'(TRFC - 1);
        bank_st_n[i] = (TRFC == 1) ? B_IDLE : B_REFRESHING;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (reset) begin
        bank_st[i]  <= B_IDLE;
        open_row[i] <= '0;
        phase[i]    <= '0;
        ras[i]      <= '0;
      end else begin
        bank_st[i]  <= bank_st_n[i];
        open_row[i] <= open_row_n[i];
        phase[i]    <= phase_n[i];
        ras[i]      <= ras_n[i];
      end
    end
  end

  assign beat_data = wr_valid ? wr_data : '0;

  always_comb begin
    eng_st_n   = eng_st;
    cnt_n      = cnt;
    beat_n     = beat;
    acc_n      = acc;
    checksum_n = wr_checksum;
    case (eng_st)
      E_IDLE: begin
        beat_n = 8'd0;
        if (rd_ok) begin
          eng_st_n = (TCL == 1) ? E_RD_BURST : E_RD_WAIT;
          cnt_n    = 8'(TCL - 1);
        end else if (wr_ok) begin
          eng_st_n = (TCWD == 1) ? E_WR_BURST : E_WR_WAIT;
          cnt_n    = 8'(TCWD - 1);
        end
      end
      E_RD_WAIT, E_WR_WAIT: begin
        if (cnt <= 8'd1) begin
          eng_st_n = (eng_st == E_RD_WAIT) ? E_RD_BURST : E_WR_BURST;
          cnt_n    = 8'd0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      E_RD_BURST: begin
        if (beat == 8'(TBURST - 1)) eng_st_n = E_IDLE;
        else beat_n = beat + 8'd1;
      end
      E_WR_BURST: begin
        acc_n = ((beat == 8'd0) ? '0 : acc) ^ beat_data;
        if (beat == 8'(TBURST - 1)) begin
          eng_st_n   = E_IDLE;
          checksum_n = acc_n;
        end else begin
          beat_n = beat + 8'd1;
        end
      end
      default: eng_st_n = E_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      eng_st      <= E_IDLE;
      cnt         <= '0;
      beat        <= '0;
      acc         <= '0;
      wr_checksum <= '0;
      code_q      <= '0;
      lat_row     <= '0;
      lat_col     <= '0;
      lat_bank    <= '0;
    end else begin
      eng_st      <= eng_st_n;
      cnt         <= cnt_n;
      beat        <= beat_n;
      acc         <= acc_n;
      wr_checksum <= checksum_n;
      if (viol_valid) code_q <= viol_code;
      if (rd_ok) begin
        lat_row  <= open_row[cmd_bank];
        lat_col  <= cmd_col;
        lat_bank <= cmd_bank;
      end
    end
  end

  assign rd_valid = (eng_st == E_RD_BURST);
  assign rd_data  = rd_valid ? DATA_W'({16'(lat_row), 10'(lat_col), 3'(lat_bank), beat[2:0]}) : '0;
  assign wr_ready = (eng_st == E_WR_BURST);
  assign wr_done  = wr_ready && (beat == 8'(TBURST - 1));
  assign viol_dp  = wr_ready && !wr_valid;

  // Command violations take priority over the data-path missing-beat code.
  assign viol_valid = !reset && ((viol_cmd != 3'd0) || viol_dp);
  assign viol_code  = (viol_cmd != 3'd0) ? viol_cmd : (viol_dp ? 3'd6 : code_q);

  always_comb begin
    bank_open = '0;
    for (int i = 0; i < NUM_BANKS; i++) bank_open[i] = (bank_st[i] == B_ACTIVE);
  end

`ifdef DDR5_RESP_VIOL_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) viol_count <= '0;
    else if (viol_valid && viol_count != 16'hFFFF) viol_count <= viol_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ddr5_bank_responder.sv
// tb/tb_ddr5_bank_responder.sv - directed bench with timestamp-based bank/burst model and per-cycle compare
module tb_ddr5_bank_responder;
  localparam int NB = 4, BW = 2, ROW_W = 16, COL_W = 10, DW = 32;
  localparam int TRCD = 4, TRP = 4, TRAS = 8, TCL = 5, TCWD = 3, TBURST = 4, TRFC = 10;
  localparam int DEPTH = 4096;
  localparam int S_IDLE = 0, S_ACTG = 1, S_ACTIVE = 2, S_PRE = 3, S_REF = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [2:0]       cmd_op = '0;
  logic [BW-1:0]    cmd_bank = '0;
  logic [ROW_W-1:0] cmd_row = '0;
  logic [COL_W-1:0] cmd_col = '0;
  logic             wr_valid = 1'b0;
  logic [DW-1:0]    wr_data = '0;
  logic             rd_valid, wr_ready, wr_done, viol_valid;
  logic [DW-1:0]    rd_data, wr_checksum;
  logic [NB-1:0]    bank_open;
  logic [2:0]       viol_code;
`ifdef DDR5_RESP_VIOL_COUNT_EN
  logic [15:0]      viol_count;
`endif

  ddr5_bank_responder dut (
`ifdef DDR5_RESP_VIOL_COUNT_EN
    .viol_count(viol_count),
`endif
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_data(wr_data), .wr_done(wr_done),
    .wr_checksum(wr_checksum), .bank_open(bank_open), .viol_valid(viol_valid), .viol_code(viol_code)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Model: each bank remembers its last accepted command and when; states follow from elapsed time.
  int          ev_kind [NB];
  int          ev_t [NB];
  int          act_t [NB];
  logic [15:0] mrow [NB];
  int          eng_free, exp_done, wr_start;
  bit          exp_rdv [DEPTH];
  logic [31:0] exp_rdd [DEPTH];
  bit          exp_wrr [DEPTH];
  logic [31:0] m_acc, m_chk;
  logic [2:0]  m_code;
  logic [15:0] m_vcnt;

  function automatic int bstat(input int b, input int now);
    case (ev_kind[b])
      1: return (now >= ev_t[b] + TRCD) ? S_ACTIVE : S_ACTG;
      2: return (now >= ev_t[b] + TRP) ? S_IDLE : S_PRE;
      3: return (now >= ev_t[b] + TRFC) ? S_IDLE : S_REF;
      default: return S_IDLE;
    endcase
  endfunction

  always @(negedge clock) begin
    int c, b, e_code, st;
    bit dp, any_busy;
    logic [2:0] x_code;
    logic [NB-1:0] x_open;
    c = cyc;
    if (reset) begin
      for (int i = 0; i < NB; i++) begin ev_kind[i] = 0; ev_t[i] = 0; act_t[i] = 0; mrow[i] = '0; end
      for (int i = 0; i < DEPTH; i++) begin exp_rdv[i] = 0; exp_rdd[i] = '0; exp_wrr[i] = 0; end
      eng_free = 0; exp_done = -1; wr_start = -1;
      m_acc = '0; m_chk = '0; m_code = '0; m_vcnt = '0;
    end else begin
      b = int'(cmd_bank);
      e_code = 0;
      if (cmd_valid) begin
        st = bstat(b, c);
        case (cmd_op)
          3'd1: if (st != S_IDLE) e_code = 1;
          3'd2, 3'd3: if (st != S_ACTIVE) e_code = 2; else if (c < eng_free) e_code = 5;
          3'd4: begin
            if (st == S_ACTIVE) begin if (c < act_t[b] + TRAS) e_code = 3; end
            else if (st != S_IDLE) e_code = 3;
          end
          3'd5: begin
            any_busy = (c < eng_free);
            for (int i = 0; i < NB; i++) if (bstat(i, c) != S_IDLE) any_busy = 1;
            if (any_busy) e_code = 4;
          end
          3'd6, 3'd7: e_code = 7;
          default: ;
        endcase
      end
      dp = exp_wrr[c] && !wr_valid;
      x_code = (e_code != 0) ? 3'(e_code) : (dp ? 3'd6 : m_code);
      for (int i = 0; i < NB; i++) x_open[i] = (bstat(i, c) == S_ACTIVE);

      chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_rdv[c]});
      chk("rd_data", rd_data, exp_rdd[c]);
      chk("wr_ready", {31'b0, wr_ready}, {31'b0, exp_wrr[c]});
      chk("wr_done", {31'b0, wr_done}, {31'b0, (c == exp_done)});
      chk("wr_checksum", wr_checksum, m_chk);
      chk("bank_open", 32'(bank_open), 32'(x_open));
      chk("viol_valid", {31'b0, viol_valid}, {31'b0, (e_code != 0 || dp)});
      chk("viol_code", 32'(viol_code), 32'(x_code));
`ifdef DDR5_RESP_VIOL_COUNT_EN
      chk("viol_count", 32'(viol_count), 32'(m_vcnt));
      if ((e_code != 0 || dp) && m_vcnt != 16'hFFFF) m_vcnt = m_vcnt + 16'd1;
`endif

      if (e_code != 0 || dp) m_code = x_code;
      if (exp_wrr[c]) begin
        if (c == wr_start) m_acc = '0;
        m_acc = m_acc ^ (wr_valid ? wr_data : 32'h0);
        if (c == exp_done) m_chk = m_acc;
      end
      if (cmd_valid && e_code == 0) begin
        case (cmd_op)
          3'd1: begin ev_kind[b] = 1; ev_t[b] = c; act_t[b] = c; mrow[b] = 16'(cmd_row); end
          3'd2: begin
            for (int k = 0; k < TBURST; k++) begin
              exp_rdv[c + TCL + k] = 1;
              exp_rdd[c + TCL + k] = (32'(mrow[b]) << 16) | (32'(cmd_col) << 6) | (32'(b) << 3) | 32'(k);
            end
            eng_free = c + TCL + TBURST;
          end
          3'd3: begin
            for (int k = 0; k < TBURST; k++) exp_wrr[c + TCWD + k] = 1;
            wr_start = c + TCWD;
            exp_done = c + TCWD + TBURST - 1;
            eng_free = c + TCWD + TBURST;
          end
          3'd4: if (bstat(b, c) == S_ACTIVE) begin ev_kind[b] = 2; ev_t[b] = c; end
          3'd5: for (int i = 0; i < NB; i++) begin ev_kind[i] = 3; ev_t[i] = c; end
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cmd(input logic [2:0] op, input int b, input int row, input int col, input int exp_code);
    cmd_valid = 1'b1; cmd_op = op; cmd_bank = BW'(b); cmd_row = ROW_W'(row); cmd_col = COL_W'(col);
    #1;
    chk("cmd_viol_valid", {31'b0, viol_valid}, {31'b0, (exp_code != 0)});
    if (exp_code != 0) chk("cmd_viol_code", 32'(viol_code), 32'(exp_code));
    tick();
    cmd_valid = 1'b0; cmd_op = '0;
  endtask

  task automatic wr_burst(input logic [3:0] mask, input logic [31:0] exp_sum);
    for (int k = 0; k < 4; k++) begin
      wr_valid = mask[k]; wr_data = 32'(1) << k;
      #1;
      chk("lit_wr_ready", {31'b0, wr_ready}, 32'd1);
      if (!mask[k]) chk("lit_code6", 32'(viol_code), 32'd6);
      if (k == 3) chk("lit_wr_done", {31'b0, wr_done}, 32'd1);
      tick();
    end
    wr_valid = 1'b0; wr_data = '0;
    #1;
    chk("lit_checksum", wr_checksum, exp_sum);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_bank_open", 32'(bank_open), 32'd0);
    chk("reset_checksum", wr_checksum, 32'd0);
    chk("reset_viol_code", 32'(viol_code), 32'd0);

    // ACT then RD at tRCD; burst at +9..+12
    cmd(3'd1, 0, 16'h1234, 0, 0);
    idle(3);
    cmd(3'd2, 0, 0, 10'h005, 0);
    idle(4);
    chk("lit_rd_first_valid", {31'b0, rd_valid}, 32'd1);
    chk("lit_rd_first", rd_data, 32'h12340140);
    idle(3);
    chk("lit_rd_last", rd_data, 32'h12340143);
    idle(1);
    chk("lit_rd_end", {31'b0, rd_valid}, 32'd0);

    // RD one cycle early then on time
    cmd(3'd1, 1, 16'h0BEE, 0, 0);
    idle(2);
    cmd(3'd2, 1, 0, 10'h007, 2);
    cmd(3'd2, 1, 0, 10'h007, 0);
    idle(9);

    // tRAS and tRP edges
    cmd(3'd1, 2, 16'h00AA, 0, 0);
    idle(6);
    cmd(3'd4, 2, 0, 0, 3);
    cmd(3'd4, 2, 0, 0, 0);
    idle(2);
    cmd(3'd1, 2, 16'h00AB, 0, 1);
    cmd(3'd1, 2, 16'h00AB, 0, 0);

    // write bursts, full and with a missing beat
    cmd(3'd3, 0, 0, 10'h020, 0);
    idle(2);
    wr_burst(4'b1111, 32'h0000000F);
    cmd(3'd3, 0, 0, 10'h021, 0);
    idle(2);
    wr_burst(4'b1101, 32'h0000000D);

    // busy engine, REF with open bank, REF timing
    cmd(3'd1, 3, 16'h0333, 0, 0);
    idle(4);
    cmd(3'd2, 0, 0, 10'h010, 0);
    idle(1);
    cmd(3'd2, 3, 0, 10'h011, 5);
    cmd(3'd5, 0, 0, 0, 4);
    idle(9);
    for (int i = 0; i < NB; i++) cmd(3'd4, i, 0, 0, 0);
    idle(3);
    cmd(3'd5, 0, 0, 0, 0);
    idle(8);
    cmd(3'd1, 0, 16'h5A5A, 0, 1);
    cmd(3'd1, 0, 16'h5A5A, 0, 0);
    cmd(3'd4, 1, 0, 0, 0);
    cmd(3'd6, 0, 0, 0, 7);
    cmd(3'd0, 2, 0, 0, 0);

    // reset in the middle of a read burst
    cmd(3'd2, 0, 0, 10'h3FF, 0);
    idle(6);
    chk("lit_rd_beat2", rd_data, 32'h5A5AFFC2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("lit_rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("lit_rst_bank_open", 32'(bank_open), 32'd0);
    cmd(3'd1, 1, 16'h0777, 0, 0);
    idle(4);
    chk("lit_post_rst_open", 32'(bank_open), 32'h2);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
